i_cache_2way: RTL and testbench

//  2-way set-associative instruction cache with multi-word lines, LRU replacement and a

---
 rtl/i_cache_2way_if.sv | 26 ++
 rtl/i_cache_2way.sv | 207 ++++++++++++++++++++
 tb/tb_i_cache_2way.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/i_cache_2way_if.sv
// Fetch-side (p_*) and refill-side (m_*) signal bundle for i_cache_2way.
// master: fetch stage plus memory bridge driving the cache; slave: the cache itself.
interface i_cache_2way_if #(
   parameter int unsigned A_WIDTH = 32
);
   logic [A_WIDTH-1:0] p_a;
   logic               p_strobe;
   logic               p_flush;
   logic [31:0]        p_din;
   logic               p_ready;
   logic               cache_miss;
   logic [A_WIDTH-1:0] m_a;
   logic               m_strobe;
   logic [31:0]        m_dout;
   logic               m_ready;

   modport master (
      output p_a, p_strobe, p_flush, m_dout, m_ready,
      input  p_din, p_ready, cache_miss, m_a, m_strobe
   );

   modport slave (
      input  p_a, p_strobe, p_flush, m_dout, m_ready,
      output p_din, p_ready, cache_miss, m_a, m_strobe
   );
endinterface

// File: rtl/i_cache_2way.sv
// 2-way set-associative instruction cache with LRU replacement and a word-by-word
// line refill FSM. Hits answer combinationally in the request cycle; a miss refills the
// whole line and the request is answered by the next IDLE lookup.
// Optional feature: define ICACHE_STATS_EN to add hit_cnt/miss_cnt counter outputs.
module i_cache_2way #(
   parameter int unsigned A_WIDTH  = 32,
   parameter int unsigned C_INDEX  = 6,
   parameter int unsigned C_OFFSET = 2
) (
   input  logic          clk,
   input  logic          rst,
   i_cache_2way_if.slave bus
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]   hit_cnt,
   output logic [31:0]   miss_cnt
`endif
);

   localparam int unsigned T_WIDTH = A_WIDTH - C_INDEX - C_OFFSET - 2;
   localparam int unsigned LINE_W  = T_WIDTH + C_INDEX;
   localparam int unsigned SETS    = 1 << C_INDEX;
   localparam int unsigned WORDS   = 1 << C_OFFSET;
   localparam logic [C_OFFSET-1:0] LAST = '1;

   typedef enum logic [0:0] {StIdle, StRefill} state_e;

   state_e              state_q, state_d;
   logic [C_OFFSET-1:0] cnt_q, cnt_d;
   logic [LINE_W-1:0]   line_a_q, line_a_d;
   logic                victim_q, victim_d;
   logic                flush_pend_q, flush_pend_d;
   logic [SETS-1:0]     valid_q [2];
   logic [SETS-1:0]     valid_d [2];
   logic [SETS-1:0]     lru_q, lru_d;

   // No reset on storage arrays; valid bits alone decide whether contents are used.
   logic [31:0]         data_q [2][SETS][WORDS];
   logic [T_WIDTH-1:0]  tag_q  [2][SETS];

   logic [T_WIDTH-1:0]  req_tag;
   logic [C_INDEX-1:0]  req_idx;
   logic [C_OFFSET-1:0] req_off;
   logic [C_INDEX-1:0]  line_idx;
   logic [T_WIDTH-1:0]  line_tag;
   logic                hit0, hit1, hit, hit_way;
   logic                unused_addr_bits;

   logic                ready;
   logic                miss;
   logic                m_strobe;
   logic [A_WIDTH-1:0]  m_addr;
   logic                data_we;
   logic                tag_we;
   logic                miss_start;
   logic                hit_take;

   assign req_tag  = bus.p_a[A_WIDTH-1 -: T_WIDTH];
   assign req_idx  = bus.p_a[C_OFFSET+2 +: C_INDEX];
   assign req_off  = bus.p_a[2 +: C_OFFSET];
   assign line_idx = line_a_q[C_INDEX-1:0];
   assign line_tag = line_a_q[LINE_W-1 -: T_WIDTH];
   assign unused_addr_bits = ^bus.p_a[1:0];

   // Tags are unique within a set, so at most one of hit0/hit1 is set.
   assign hit0    = valid_q[0][req_idx] & (tag_q[0][req_idx] == req_tag);
   assign hit1    = valid_q[1][req_idx] & (tag_q[1][req_idx] == req_tag);
   assign hit     = hit0 | hit1;
   assign hit_way = hit1;

   assign bus.p_din      = data_q[hit_way][req_idx][req_off];
   assign bus.p_ready    = ready;
   assign bus.cache_miss = miss;
   assign bus.m_strobe   = m_strobe;
   assign bus.m_a        = m_addr;

   // Next-state, lookup response and refill control.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      line_a_d     = line_a_q;
      victim_d     = victim_q;
      flush_pend_d = flush_pend_q;
      valid_d      = valid_q;
      lru_d        = lru_q;
      ready        = 1'b0;
      miss         = 1'b0;
      m_strobe     = 1'b0;
      m_addr       = '0;
      data_we      = 1'b0;
      tag_we       = 1'b0;
      miss_start   = 1'b0;
      hit_take     = 1'b0;
      unique case (state_q)
         StIdle: begin
            miss = bus.p_strobe & ~hit;
            if (bus.p_flush) begin
               // Flush wins over a simultaneous fetch, even one that would hit.
               valid_d[0] = '0;
               valid_d[1] = '0;
            end else if (bus.p_strobe) begin
               if (hit) begin
                  ready          = 1'b1;
                  hit_take       = 1'b1;
                  lru_d[req_idx] = ~hit_way;
               end else begin
                  line_a_d = bus.p_a[A_WIDTH-1 -: LINE_W];
                  if (!valid_q[0][req_idx]) begin
                     victim_d = 1'b0;
                  end else if (!valid_q[1][req_idx]) begin
                     victim_d = 1'b1;
                  end else begin
                     victim_d = lru_q[req_idx];
                  end
                  cnt_d      = '0;
                  miss_start = 1'b1;
                  state_d    = StRefill;
               end
            end
         end
         StRefill: begin
            miss     = 1'b1;
            m_strobe = 1'b1;
            m_addr   = {line_a_q, cnt_q, 2'b00};
            if (bus.p_flush) begin
               flush_pend_d = 1'b1;
            end
            if (bus.m_ready) begin
               data_we = 1'b1;
               cnt_d   = cnt_q + C_OFFSET'(1);
               if (cnt_q == LAST) begin
                  // A flush seen at any point of the refill discards the line.
                  if (flush_pend_q | bus.p_flush) begin
                     valid_d[0] = '0;
                     valid_d[1] = '0;
                  end else begin
                     valid_d[victim_q][line_idx] = 1'b1;
                     tag_we = 1'b1;
                  end
                  lru_d[line_idx] = ~victim_q;
                  flush_pend_d    = 1'b0;
                  state_d         = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Control state, valid and LRU bits with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         line_a_q     <= '0;
         victim_q     <= 1'b0;
         flush_pend_q <= 1'b0;
         valid_q[0]   <= '0;
         valid_q[1]   <= '0;
         lru_q        <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         line_a_q     <= line_a_d;
         victim_q     <= victim_d;
         flush_pend_q <= flush_pend_d;
         valid_q      <= valid_d;
         lru_q        <= lru_d;
      end
   end

   // Refill writes into the data and tag arrays.
   always_ff @(posedge clk) begin
      if (data_we) begin
         data_q[victim_q][line_idx][cnt_q] <= bus.m_dout;
      end
      if (tag_we) begin
         tag_q[victim_q][line_idx] <= line_tag;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   // Performance counters; they survive p_flush and wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (hit_take) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
         end
         if (miss_start) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`else
   logic unused_stats;
   assign unused_stats = hit_take ^ miss_start;
`endif

endmodule

// File: tb/tb_i_cache_2way.sv
// Directed bench for i_cache_2way: a behavioural memory answers refills, expected
// instruction words and refill addresses are queued when a fetch is issued and popped
// as the cache produces them.
module tb_i_cache_2way;
   localparam int unsigned A_WIDTH = 32;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] exp_q [$];
   logic [31:0] ma_q [$];

   always #5 clk = ~clk;

   i_cache_2way_if #(.A_WIDTH(A_WIDTH)) bus ();

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   i_cache_2way #(
      .A_WIDTH (A_WIDTH),
      .C_INDEX (6),
      .C_OFFSET(2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus)
`ifdef ICACHE_STATS_EN
      ,
      .hit_cnt (hit_cnt),
      .miss_cnt(miss_cnt)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a * 32'h9E37_79B1 + 32'h1234_5678;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one fetch (entered and left at posedge+1). exp_lat is the cycle index at which
   // p_ready is expected, n_refills how many line refills precede it, flush_word the
   // refill word (of the first refill) during which p_flush is pulsed, or -1.
   task automatic fetch(input logic [31:0] addr, input int exp_lat, input int n_refills,
                        input int flush_word);
      int cyc = 0;
      int words = 0;
      bit done = 0;
      bus.p_a      = addr;
      bus.p_strobe = 1'b1;
      bus.m_ready  = 1'b1;
      exp_q.push_back(mem_word(addr));
      for (int r = 0; r < n_refills; r++) begin
         for (int w = 0; w < 4; w++) begin
            ma_q.push_back({addr[31:4], 4'(w * 4)});
         end
      end
      while (!done && cyc < 40) begin
         @(negedge clk);
         if (cyc == 0) check("cache_miss", 32'(bus.cache_miss), 32'(n_refills > 0));
         if (bus.m_strobe) begin
            bus.m_dout = mem_word(bus.m_a);
            if (ma_q.size() == 0) ma_q.push_back(32'hDEAD_BEEF);
            check("m_a", bus.m_a, ma_q.pop_front());
            if (words == flush_word) bus.p_flush = 1'b1;
            words++;
         end
         if (bus.p_ready) begin
            check("p_din", bus.p_din, exp_q.pop_front());
            check("latency", 32'(cyc), 32'(exp_lat));
            done = 1;
         end
         @(posedge clk);
         #1;
         bus.p_flush = 1'b0;
         cyc++;
      end
      if (!done) begin
         check("p_ready_timeout", 32'(cyc), 32'(exp_lat));
         void'(exp_q.pop_front());
      end
      bus.p_strobe = 1'b0;
      bus.m_ready  = 1'b0;
      check("m_a_outstanding", 32'(ma_q.size()), 32'd0);
      ma_q.delete();
   endtask

   initial begin
      rst          = 1'b1;
      bus.p_a      = '0;
      bus.p_strobe = 1'b0;
      bus.p_flush  = 1'b0;
      bus.m_dout   = '0;
      bus.m_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_p_ready", 32'(bus.p_ready), 32'd0);
      check("rst_m_strobe", 32'(bus.m_strobe), 32'd0);
      check("rst_m_a", bus.m_a, 32'd0);
      check("rst_cache_miss", 32'(bus.cache_miss), 32'd0);
      @(posedge clk);
      #1;

      // T1 cold miss, T2 hit on the same line
      fetch(32'h100, 5, 1, -1);
      fetch(32'h108, 0, 0, -1);
`ifdef ICACHE_STATS_EN
      check("hit_cnt", hit_cnt, 32'd2);
      check("miss_cnt", miss_cnt, 32'd1);
`endif

      // T3 LRU replacement within set 0x10
      fetch(32'h1100, 5, 1, -1);
      fetch(32'h100, 0, 0, -1);
      fetch(32'h2100, 5, 1, -1);
      fetch(32'h104, 0, 0, -1);
      fetch(32'h1100, 5, 1, -1);
      fetch(32'h10C, 0, 0, -1);
      fetch(32'h1104, 0, 0, -1);

      // T4 flush during refill word 2: line discarded, refilled again, others lost
      fetch(32'h300, 10, 2, 2);
      fetch(32'h30C, 0, 0, -1);
      fetch(32'h100, 5, 1, -1);
      fetch(32'h1100, 5, 1, -1);

      // T5 flush and hitting fetch in the same cycle
      bus.p_a      = 32'h100;
      bus.p_strobe = 1'b1;
      bus.p_flush  = 1'b1;
      @(negedge clk);
      check("t5_p_ready", 32'(bus.p_ready), 32'd0);
      check("t5_cache_miss", 32'(bus.cache_miss), 32'd0);
      @(posedge clk);
      #1;
      bus.p_flush = 1'b0;
      fetch(32'h100, 5, 1, -1);

      // T6 reset in the middle of a refill
      bus.p_a      = 32'h500;
      bus.p_strobe = 1'b1;
      bus.m_ready  = 1'b1;
      bus.m_dout   = 32'h0;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("t6_refill_m_strobe", 32'(bus.m_strobe), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("t6_rst_m_strobe", 32'(bus.m_strobe), 32'd0);
      check("t6_rst_p_ready", 32'(bus.p_ready), 32'd0);
      check("t6_rst_m_a", bus.m_a, 32'd0);
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.p_strobe = 1'b0;
      bus.m_ready  = 1'b0;
      fetch(32'h100, 5, 1, -1);
      fetch(32'h500, 5, 1, -1);
      fetch(32'h504, 0, 0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
